// File: rtl/game_collision_scheduler.sv
// Time-multiplexed collision controller: snapshots target boxes on a frame strobe,
// then checks one unordered target pair per clock through a shared overlap comparator.
module game_collision_scheduler #(
    parameter int N_TARGETS       = 4,
    parameter int w_x             = $clog2(640),
    parameter int w_y             = $clog2(480),
    parameter int IMMUNITY_FRAMES = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N_TARGETS-1:0][w_x-1:0] sprite_left,
    input  logic [N_TARGETS-1:0][w_x-1:0] sprite_right,
    input  logic [N_TARGETS-1:0][w_y-1:0] sprite_top,
    input  logic [N_TARGETS-1:0][w_y-1:0] sprite_bottom,
    output logic                          busy,
    output logic                          done,
    output logic [N_TARGETS-1:0]          collide_x,
    output logic [N_TARGETS-1:0]          collide_y
);

    localparam int P  = N_TARGETS * (N_TARGETS - 1) / 2;
    localparam int IW = $clog2(N_TARGETS);
    localparam int KW = (P > 1) ? $clog2(P) : 1;
    localparam int CW = $clog2(IMMUNITY_FRAMES + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_TARGETS - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(P - 1);
    localparam logic [CW-1:0] IMM_LOAD = CW'(IMMUNITY_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [N_TARGETS-1:0][w_x-1:0] snap_left_q,   snap_left_d;
    logic [N_TARGETS-1:0][w_x-1:0] snap_right_q,  snap_right_d;
    logic [N_TARGETS-1:0][w_y-1:0] snap_top_q,    snap_top_d;
    logic [N_TARGETS-1:0][w_y-1:0] snap_bottom_q, snap_bottom_d;

    logic [IW-1:0]        i_q, i_d;
    logic [IW-1:0]        j_q, j_d;
    logic [KW-1:0]        k_q, k_d;
    logic [N_TARGETS-1:0] shadow_q, shadow_d;
    logic [N_TARGETS-1:0] collide_q, collide_d;

    // One immunity counter per upper-triangle pair, indexed by lexicographic pair number.
    logic [CW-1:0] imm_q [P];
    logic [CW-1:0] imm_d [P];

    logic overlap;

    assign overlap = (snap_left_q[i_q]   < snap_right_q[j_q])  &&
                     (snap_right_q[i_q]  > snap_left_q[j_q])   &&
                     (snap_top_q[i_q]    < snap_bottom_q[j_q]) &&
                     (snap_bottom_q[i_q] > snap_top_q[j_q]);

    always_comb begin
        state_d       = state_q;
        snap_left_d   = snap_left_q;
        snap_right_d  = snap_right_q;
        snap_top_d    = snap_top_q;
        snap_bottom_d = snap_bottom_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        shadow_d      = shadow_q;
        collide_d     = collide_q;
        imm_d         = imm_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_left_d   = sprite_left;
                    snap_right_d  = sprite_right;
                    snap_top_d    = sprite_top;
                    snap_bottom_d = sprite_bottom;
                    shadow_d      = '0;
                    i_d           = '0;
                    j_d           = IW'(1);
                    k_d           = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (imm_q[k_q] != '0) begin
                    imm_d[k_q] = imm_q[k_q] - CW'(1);
                end else if (overlap) begin
                    shadow_d[i_q] = 1'b1;
                    shadow_d[j_q] = 1'b1;
                    imm_d[k_q]    = IMM_LOAD;
                end

                // Publish on the way into DONE so flags are valid while done is high.
                if (k_q == LAST_K) begin
                    collide_d = shadow_d;
                    state_d   = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                    if (j_q == LAST_IDX) begin
                        i_d = i_q + IW'(1);
                        j_d = i_q + IW'(2);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            snap_left_q   <= '0;
            snap_right_q  <= '0;
            snap_top_q    <= '0;
            snap_bottom_q <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            shadow_q      <= '0;
            collide_q     <= '0;
            for (int p = 0; p < P; p++) begin
                imm_q[p] <= '0;
            end
        end else begin
            state_q       <= state_d;
            snap_left_q   <= snap_left_d;
            snap_right_q  <= snap_right_d;
            snap_top_q    <= snap_top_d;
            snap_bottom_q <= snap_bottom_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            shadow_q      <= shadow_d;
            collide_q     <= collide_d;
            for (int p = 0; p < P; p++) begin
                imm_q[p] <= imm_d[p];
            end
        end
    end

    assign busy      = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign collide_x = collide_q;
    assign collide_y = collide_q;

endmodule

// File: tb/tb_game_collision_scheduler.sv
// Bench for game_collision_scheduler: directed frame scenarios plus randomized boxes,
// compared against a per-scan pairwise overlap model with frame-counted immunity.
module tb_game_collision_scheduler;

    localparam int N   = 4;
    localparam int P   = N * (N - 1) / 2;
    localparam int IMM = 5;
    localparam int WX  = $clog2(640);
    localparam int WY  = $clog2(480);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [N-1:0][WX-1:0]  sprite_left;
    logic [N-1:0][WX-1:0]  sprite_right;
    logic [N-1:0][WY-1:0]  sprite_top;
    logic [N-1:0][WY-1:0]  sprite_bottom;
    logic                  busy;
    logic                  done;
    logic [N-1:0]          collide_x;
    logic [N-1:0]          collide_y;

    int checks   = 0;
    int failures = 0;

    int bl [N];
    int br [N];
    int bt [N];
    int bb [N];
    int immModel [N][N];
    logic [N-1:0] expFlags;
    logic [N-1:0] shownFlags;

    game_collision_scheduler #(
        .N_TARGETS(N),
        .w_x(WX),
        .w_y(WY),
        .IMMUNITY_FRAMES(IMM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .sprite_left(sprite_left),
        .sprite_right(sprite_right),
        .sprite_top(sprite_top),
        .sprite_bottom(sprite_bottom),
        .busy(busy),
        .done(done),
        .collide_x(collide_x),
        .collide_y(collide_y)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveBoxes();
        for (int i = 0; i < N; i++) begin
            sprite_left[i]   = WX'(bl[i]);
            sprite_right[i]  = WX'(br[i]);
            sprite_top[i]    = WY'(bt[i]);
            sprite_bottom[i] = WY'(bb[i]);
        end
    endtask

    task automatic setBox(input int idx, input int l, input int r, input int t, input int b);
        bl[idx] = l;
        br[idx] = r;
        bt[idx] = t;
        bb[idx] = b;
    endtask

    task automatic randomBoxes();
        for (int i = 0; i < N; i++) begin
            bl[i] = int'($urandom_range(0, 60));
            br[i] = bl[i] + int'($urandom_range(0, 25));
            bt[i] = int'($urandom_range(0, 60));
            bb[i] = bt[i] + int'($urandom_range(0, 25));
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                immModel[i][j] = 0;
        shownFlags = '0;
    endtask

    // One frame's worth of results from the boxes present when start is accepted.
    task automatic modelScan(output logic [N-1:0] flags);
        flags = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (immModel[i][j] > 0) begin
                    immModel[i][j]--;
                end else if (bl[i] < br[j] && br[i] > bl[j] && bt[i] < bb[j] && bb[i] > bt[j]) begin
                    flags[i] = 1'b1;
                    flags[j] = 1'b1;
                    immModel[i][j] = IMM;
                end
            end
        end
    endtask

    // moveMode: 0 keep boxes, 1 move T2 far away after start, 2 randomize after start.
    task automatic applyStimulus(input string tag, input bit midStart, input int moveMode);
        @(negedge clk);
        driveBoxes();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        modelScan(expFlags);
        if (moveMode == 1) setBox(2, 500, 600, 400, 450);
        if (moveMode == 2) randomBoxes();
        driveBoxes();
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            if (midStart && c == 2) start = 1'b1;
            if (midStart && c == 3) start = 1'b0;
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            checkOutput({tag, " done early"}, 32'(done), 32'd0);
            checkOutput({tag, " held flags"}, 32'(collide_x), 32'(shownFlags));
        end
        @(negedge clk);
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
        checkOutput({tag, " collide_x"}, 32'(collide_x), 32'(expFlags));
        checkOutput({tag, " collide_y"}, 32'(collide_y), 32'(expFlags));
        shownFlags = expFlags;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput({tag, " idle done"}, 32'(done), 32'd0);
            checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset collide_x", 32'(collide_x), 32'd0);
        checkOutput("reset collide_y", 32'(collide_y), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
    endtask

    task automatic farLayout();
        setBox(0, 0,   50,  0,   50);
        setBox(1, 100, 150, 0,   50);
        setBox(2, 200, 250, 0,   50);
        setBox(3, 300, 350, 0,   50);
    endtask

    task automatic overlapLayout();
        setBox(0, 10,  20,  10,  20);
        setBox(1, 300, 350, 300, 350);
        setBox(2, 15,  25,  15,  25);
        setBox(3, 400, 450, 100, 150);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        farLayout();
        driveBoxes();
        clearModel();
        repeat (3) @(negedge clk);
        checkOutput("por busy", 32'(busy), 32'd0);
        checkOutput("por done", 32'(done), 32'd0);
        checkOutput("por collide_x", 32'(collide_x), 32'd0);
        checkOutput("por collide_y", 32'(collide_y), 32'd0);
        rst = 1'b0;

        applyStimulus("disjoint", 1'b0, 0);
        checkOutput("disjoint const", 32'(collide_x), 32'h0);

        overlapLayout();
        applyStimulus("overlap02", 1'b0, 0);
        checkOutput("overlap02 const", 32'(collide_x), 32'h5);

        setBox(2, 500, 550, 400, 450);
        setBox(1, 20, 30, 10, 20);
        applyStimulus("touching", 1'b0, 0);
        checkOutput("touching const", 32'(collide_x), 32'h0);

        doReset();
        overlapLayout();
        for (int s = 1; s <= 7; s++) begin
            applyStimulus("immunity", 1'b0, 0);
            checkOutput("immunity const", 32'(collide_x), (s == 1 || s == 7) ? 32'h5 : 32'h0);
        end

        doReset();
        overlapLayout();
        applyStimulus("midstart", 1'b1, 1);
        checkOutput("midstart const", 32'(collide_x), 32'h5);

        doReset();
        overlapLayout();
        applyStimulus("prereset", 1'b0, 0);
        checkOutput("prereset const", 32'(collide_x), 32'h5);
        @(negedge clk);
        driveBoxes();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort collide_x", 32'(collide_x), 32'd0);
        checkOutput("abort collide_y", 32'(collide_y), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        for (int c = 0; c < P + 2; c++) begin
            @(negedge clk);
            checkOutput("abort no done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        clearModel();
        applyStimulus("rescan", 1'b0, 0);
        checkOutput("rescan const", 32'(collide_x), 32'h5);

        doReset();
        for (int s = 0; s < 30; s++) begin
            randomBoxes();
            applyStimulus("random", 1'b0, (s % 3 == 0) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_collision_scheduler.md
# game_collision_scheduler

Time-multiplexed collision controller for the target sprites. On each frame strobe it snapshots all target bounding boxes, then walks every unordered target pair (i<j) one pair per clock through a single overlap comparator. It applies per-pair immunity counted in frames, and publishes per-target collision flags once per scan. It sits between the target sprite position logic and the target bounce/motion logic, replacing a fully parallel N² comparator array.

## Interface

- N_TARGETS, `N_TARGETS` (from game_config.svh), number of targets; must be ≥ 2.
- w_x, $clog2(640), X coordinate width.
- w_y, $clog2(480), Y coordinate width.
- IMMUNITY_FRAMES, 5, number of scans a pair is suppressed after a reported collision; must be ≥ 1.

- clk  in  1  system clock; the block uses this single clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  frame strobe; requests a scan.
- sprite_left  in  [N_TARGETS-1:0][w_x-1:0]  per-target left edge.
- sprite_right  in  [N_TARGETS-1:0][w_x-1:0]  per-target right edge.
- sprite_top  in  [N_TARGETS-1:0][w_y-1:0]  per-target top edge.
- sprite_bottom  in  [N_TARGETS-1:0][w_y-1:0]  per-target bottom edge.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when new results are published.
- collide_x  out  [N_TARGETS-1:0]  per-target collision flag, held between scans.
- collide_y  out  [N_TARGETS-1:0]  per-target collision flag, held between scans; always equal to collide_x.

## Operation

- P = N_TARGETS*(N_TARGETS-1)/2 pairs.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start=1 → capture all four bound arrays into the snapshot registers, clear the shadow flags, set pair (i,j)=(0,1), go to SCAN.
  - SCAN: evaluate one pair per cycle from the snapshot. Pair order is lexicographic: (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1). After pair (N-2,N-1), go to DONE.
  - DONE: copy the shadow flags to collide_x/collide_y, pulse done, return to IDLE.
- start is only accepted in IDLE. It is ignored in SCAN and DONE and is not queued.
- Overlap test uses strict compares on unsigned values: (L_i < R_j) && (R_i > L_j) && (T_i < B_j) && (B_i > T_j). Edges that only touch do not overlap.
- Each pair (i<j) has an immunity counter of width $clog2(IMMUNITY_FRAMES+1). Only the upper triangle is implemented.
- Evaluation of pair (i,j):
  - Counter ≠ 0: decrement by 1. No flag is set, whatever the overlap result.
  - Counter = 0 and overlap: set shadow flags i and j, load counter = IMMUNITY_FRAMES.
  - Counter = 0 and no overlap: no action.
- Result: after a reported collision, the pair is suppressed for exactly IMMUNITY_FRAMES subsequent scans. Counters only change during SCAN.
- Shadow flags OR-accumulate across pairs. A target in several colliding pairs gets one flag.
- Inputs may change freely after the start cycle. Only the snapshot is used.

## Timing

- Reset (asynchronous) values:
  - FSM = IDLE.
  - busy = 0, done = 0.
  - collide_x = 0, collide_y = 0.
  - All immunity counters = 0; snapshot and shadow flags = 0.
- Reset mid-scan aborts the scan. No done pulse follows. Outputs return to 0.
- Start accepted at edge 0. busy = 1 from edge 1 through edge P (P SCAN cycles). At edge P+1: DONE is active, done = 1, and collide_* update. FSM is back in IDLE at edge P+2.
- Scan latency, start to done: P+1 cycles.
- Minimum start-to-start period: P+2 cycles.
- Flag outputs are registered and change only on the done cycle or on reset.

## Test plan

Defaults: N_TARGETS=4 (P=6), IMMUNITY_FRAMES=5.

1. All targets disjoint, start pulse → busy high 6 cycles, done exactly 7 cycles after start, collide_x = collide_y = 4'b0000.
2. T0 = [10,20]×[10,20], T2 = [15,25]×[15,25], others far away → collide_x = collide_y = 4'b0101 at done.
3. T0 right = 20 and T1 left = 20, y ranges overlapping → 4'b0000 (touching edges are not a collision).
4. T0/T2 overlap held constant over 7 consecutive scans → flags 4'b0101 on scans 1 and 7, 4'b0000 on scans 2–6.
5. Move T2 away on the cycle after start, and pulse start again mid-scan → result still 4'b0101, a single done pulse, second start ignored.
6. Assert rst during SCAN after a scan-1 collision, then rescan with the overlap still present → outputs 0 during reset, no done pulse from the aborted scan, next scan reports 4'b0101 (counters were cleared).
